// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, channel type and FSM states for the memory issuer
package mem_pkg;
   localparam int CH_BIT = 25;
   localparam int WR_BIT = 31;
   localparam int ADDR_W = 26;
   localparam int SLOTS_PER_CH_DEF = 10;

   typedef logic [0:0] ch_t;

   typedef enum logic [1:0] {IDLE, ISSUE, BLOCKED, DRAIN} state_t;

   function automatic ch_t chan_of(input logic [31:0] instr);
      logic [ADDR_W-1:0] addr;
      addr = instr[ADDR_W-1:0];
      return addr[CH_BIT];
   endfunction
endpackage

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - synchronous request FIFO with registered occupancy and head-of-queue view
module issue_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/mem_issuer.sv
// rtl/mem_issuer.sv - in-order request issuer with per-channel slot credits
// Optional watchdog and timeout_err port under MEM_ISSUER_TIMEOUT_EN.
module mem_issuer
   import mem_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int SLOTS_PER_CH = SLOTS_PER_CH_DEF
`ifdef MEM_ISSUER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_instr,
   output logic        req_ready,
   input  logic        drain,
   output logic [31:0] instruction,
   output logic        m_grant,
   output logic        write_enable,
   input  logic        mem_request,
   input  logic [31:0] data,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [3:0]  outstanding_ch0,
   output logic [3:0]  outstanding_ch1,
   output logic [31:0] issued_count,
   output logic [31:0] completed_count,
   output logic        drain_done,
`ifdef MEM_ISSUER_TIMEOUT_EN
   output logic        timeout_err,
`endif
   output logic        spurious_err
);
   localparam logic [3:0] SLOTS = 4'(SLOTS_PER_CH);

   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic [31:0] head;
   state_t      state;
   state_t      next_state;
   ch_t         head_ch;
   ch_t         cmp_ch;
   logic [3:0]  head_cnt;
   logic        cmp_ok;
   logic        inc0, inc1, dec0, dec1;

   assign req_ready = !full;
   assign push      = req_valid && !full;

   issue_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (req_instr),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head      (head)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // A full channel stalls the head and therefore everything behind it.
   always_comb begin
      next_state = IDLE;
      head_ch    = chan_of(head);
      cmp_ch     = chan_of(data);
      head_cnt   = (head_ch == 1'b1) ? outstanding_ch1 : outstanding_ch0;
      if (drain)                next_state = DRAIN;
      else if (empty)           next_state = IDLE;
      else if (head_cnt == SLOTS) next_state = BLOCKED;
      else                      next_state = ISSUE;
      pop    = (next_state == ISSUE);
      cmp_ok = mem_request &&
               (((cmp_ch == 1'b1) ? outstanding_ch1 : outstanding_ch0) != 4'd0);
      inc0   = pop && (head_ch == 1'b0);
      inc1   = pop && (head_ch == 1'b1);
      dec0   = cmp_ok && (cmp_ch == 1'b0);
      dec1   = cmp_ok && (cmp_ch == 1'b1);
   end

   assign m_grant      = (state == ISSUE);
   assign write_enable = m_grant && instruction[WR_BIT];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instruction     <= '0;
         outstanding_ch0 <= '0;
         outstanding_ch1 <= '0;
         issued_count    <= '0;
         completed_count <= '0;
         resp_valid      <= 1'b0;
         resp_data       <= '0;
         spurious_err    <= 1'b0;
         drain_done      <= 1'b0;
      end else begin
         if (pop) begin
            instruction  <= head;
            issued_count <= issued_count + 32'd1;
         end
         outstanding_ch0 <= outstanding_ch0 + {3'b0, inc0} - {3'b0, dec0};
         outstanding_ch1 <= outstanding_ch1 + {3'b0, inc1} - {3'b0, dec1};
         resp_valid      <= cmp_ok;
         if (cmp_ok) begin
            resp_data       <= data;
            completed_count <= completed_count + 32'd1;
         end
         if (mem_request && !cmp_ok) spurious_err <= 1'b1;
         drain_done <= drain && empty && (outstanding_ch0 == 4'd0) && (outstanding_ch1 == 4'd0);
      end
   end

`ifdef MEM_ISSUER_TIMEOUT_EN
   logic [31:0] wd_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else if (cmp_ok || ((outstanding_ch0 == 4'd0) && (outstanding_ch1 == 4'd0))) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 32'd1;
         if (wd_cnt + 32'd1 == 32'(TIMEOUT_CYCLES)) timeout_err <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_mem_issuer.sv
// tb/tb_mem_issuer.sv - scoreboard bench for mem_issuer grants, credits, completions and drain
module tb_mem_issuer;
   logic        clock;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_instr;
   logic        req_ready;
   logic        drain;
   logic [31:0] instruction;
   logic        m_grant;
   logic        write_enable;
   logic        mem_request;
   logic [31:0] data;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [3:0]  outstanding_ch0;
   logic [3:0]  outstanding_ch1;
   logic [31:0] issued_count;
   logic [31:0] completed_count;
   logic        drain_done;
   logic        spurious_err;

   int          checks;
   int          errors;
   int          cycle;
   int          grants_seen;
   int          gcyc[$];
   logic [31:0] exp_grant[$];
   logic [31:0] exp_resp[$];
   logic [31:0] mon_e;

   mem_issuer dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_instr       (req_instr),
      .req_ready       (req_ready),
      .drain           (drain),
      .instruction     (instruction),
      .m_grant         (m_grant),
      .write_enable    (write_enable),
      .mem_request     (mem_request),
      .data            (data),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .outstanding_ch0 (outstanding_ch0),
      .outstanding_ch1 (outstanding_ch1),
      .issued_count    (issued_count),
      .completed_count (completed_count),
      .drain_done      (drain_done),
      .spurious_err    (spurious_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cycle++;

   always @(negedge clock) begin
      checks++;
      if (!m_grant && write_enable !== 1'b0) begin
         errors++;
         $display("FAIL idle_write_enable got %b exp 0", write_enable);
      end
      if (m_grant) begin
         grants_seen++;
         gcyc.push_back(cycle);
         checks++;
         if (exp_grant.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected instruction %h exp no grant", instruction);
         end else begin
            mon_e = exp_grant.pop_front();
            if (instruction !== mon_e || write_enable !== mon_e[31]) begin
               errors++;
               $display("FAIL grant_order instruction %h we %b exp %h we %b",
                        instruction, write_enable, mon_e, mon_e[31]);
            end
         end
      end
      if (resp_valid) begin
         checks++;
         if (exp_resp.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected resp_data %h exp no response", resp_data);
         end else begin
            mon_e = exp_resp.pop_front();
            if (resp_data !== mon_e) begin
               errors++;
               $display("FAIL resp_data got %h exp %h", resp_data, mon_e);
            end
         end
      end
   end

   task tick();
      @(posedge clock);
      #1;
   endtask

   task wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task do_reset();
      reset = 1'b1;
      req_valid = 1'b0;
      mem_request = 1'b0;
      drain = 1'b0;
      tick();
      exp_grant.delete();
      exp_resp.delete();
      gcyc.delete();
      reset = 1'b0;
      tick();
   endtask

   task push_req(input logic [31:0] instr);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL push_ready_timeout got req_ready %b exp 1", req_ready);
      end
      req_valid = 1'b1;
      req_instr = instr;
      exp_grant.push_back(instr);
      tick();
      req_valid = 1'b0;
   endtask

   task complete(input logic [31:0] instr, input bit ok);
      mem_request = 1'b1;
      data = instr;
      if (ok) exp_resp.push_back(instr);
      tick();
      mem_request = 1'b0;
   endtask

   task test_reset();
      reset = 1'b1;
      req_valid = 1'b0;
      req_instr = '0;
      drain = 1'b0;
      mem_request = 1'b0;
      data = '0;
      tick();
      checks++;
      if ({m_grant, write_enable, resp_valid, drain_done, spurious_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 00000",
                  {m_grant, write_enable, resp_valid, drain_done, spurious_err});
      end
      checks++;
      if (instruction !== 32'h0 || issued_count !== 32'h0 || completed_count !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs got instr %h issued %0d completed %0d exp 0 0 0",
                  instruction, issued_count, completed_count);
      end
      checks++;
      if (outstanding_ch0 !== 4'd0 || outstanding_ch1 !== 4'd0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_credits got ch0 %0d ch1 %0d ready %b exp 0 0 1",
                  outstanding_ch0, outstanding_ch1, req_ready);
      end
      reset = 1'b0;
      tick();
   endtask

   task test_basic();
      int base;
      do_reset();
      base = grants_seen;
      push_req(32'h0000_0400);
      push_req(32'h8000_0800);
      push_req(32'h0000_0C00);
      wait_cycles(3);
      checks++;
      if (grants_seen - base !== 3) begin
         errors++;
         $display("FAIL basic_grants got %0d exp 3", grants_seen - base);
      end
      checks++;
      if (gcyc.size() < 3 || gcyc[2] - gcyc[0] !== 2) begin
         errors++;
         $display("FAIL basic_consecutive got %0d grants spread %0d exp 3 spread 2",
                  gcyc.size(), (gcyc.size() < 3) ? -1 : gcyc[2] - gcyc[0]);
      end
      checks++;
      if (outstanding_ch0 !== 4'd3 || outstanding_ch1 !== 4'd0 || issued_count !== 32'd3) begin
         errors++;
         $display("FAIL basic_counts got ch0 %0d ch1 %0d issued %0d exp 3 0 3",
                  outstanding_ch0, outstanding_ch1, issued_count);
      end
   endtask

   task test_block();
      int base;
      int late;
      do_reset();
      base = grants_seen;
      for (int i = 0; i < 12; i++) push_req(32'h0200_0000 | (32'(i) << 4));
      wait_cycles(4);
      checks++;
      if (grants_seen - base !== 10 || outstanding_ch1 !== 4'd10 || issued_count !== 32'd10) begin
         errors++;
         $display("FAIL block_limit got grants %0d ch1 %0d issued %0d exp 10 10 10",
                  grants_seen - base, outstanding_ch1, issued_count);
      end
      late = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (m_grant) late++;
      end
      checks++;
      if (late !== 0) begin
         errors++;
         $display("FAIL block_stall got %0d grants exp 0", late);
      end
      complete(32'h0200_0000, 1'b1);
      checks++;
      if (m_grant !== 1'b0 || resp_valid !== 1'b1 || outstanding_ch1 !== 4'd9) begin
         errors++;
         $display("FAIL block_release_cycle got grant %b resp %b ch1 %0d exp 0 1 9",
                  m_grant, resp_valid, outstanding_ch1);
      end
      tick();
      checks++;
      if (m_grant !== 1'b1 || instruction !== 32'h0200_00A0 || outstanding_ch1 !== 4'd10) begin
         errors++;
         $display("FAIL block_eleventh got grant %b instr %h ch1 %0d exp 1 020000a0 10",
                  m_grant, instruction, outstanding_ch1);
      end
   endtask

   task test_hol();
      int base;
      do_reset();
      base = grants_seen;
      for (int i = 0; i < 10; i++) push_req(32'h0000_1000 + (32'(i) << 4));
      push_req(32'h0000_2000);
      push_req(32'h0200_3000);
      wait_cycles(6);
      checks++;
      if (grants_seen - base !== 10 || outstanding_ch0 !== 4'd10 || outstanding_ch1 !== 4'd0) begin
         errors++;
         $display("FAIL hol_stall got grants %0d ch0 %0d ch1 %0d exp 10 10 0",
                  grants_seen - base, outstanding_ch0, outstanding_ch1);
      end
      complete(32'h0000_1000, 1'b1);
      wait_cycles(3);
      checks++;
      if (grants_seen - base !== 12 || outstanding_ch0 !== 4'd10 || outstanding_ch1 !== 4'd1) begin
         errors++;
         $display("FAIL hol_release got grants %0d ch0 %0d ch1 %0d exp 12 10 1",
                  grants_seen - base, outstanding_ch0, outstanding_ch1);
      end
   endtask

   task test_simultaneous();
      do_reset();
      for (int i = 0; i < 5; i++) push_req(32'h0000_0100 + (32'(i) << 8));
      wait_cycles(3);
      checks++;
      if (outstanding_ch0 !== 4'd5) begin
         errors++;
         $display("FAIL simul_pre got ch0 %0d exp 5", outstanding_ch0);
      end
      req_valid = 1'b1;
      req_instr = 32'h8000_0F00;
      exp_grant.push_back(32'h8000_0F00);
      tick();
      req_valid = 1'b0;
      complete(32'h0000_0100, 1'b1);
      checks++;
      if (m_grant !== 1'b1 || resp_valid !== 1'b1 || resp_data !== 32'h0000_0100) begin
         errors++;
         $display("FAIL simul_strobes got grant %b resp %b data %h exp 1 1 00000100",
                  m_grant, resp_valid, resp_data);
      end
      checks++;
      if (outstanding_ch0 !== 4'd5 || issued_count !== 32'd6 || completed_count !== 32'd1) begin
         errors++;
         $display("FAIL simul_counts got ch0 %0d issued %0d completed %0d exp 5 6 1",
                  outstanding_ch0, issued_count, completed_count);
      end
   endtask

   task test_spurious();
      do_reset();
      complete(32'h0000_0400, 1'b0);
      checks++;
      if (spurious_err !== 1'b1 || resp_valid !== 1'b0 || completed_count !== 32'd0) begin
         errors++;
         $display("FAIL spurious_flag got err %b resp %b completed %0d exp 1 0 0",
                  spurious_err, resp_valid, completed_count);
      end
      wait_cycles(3);
      checks++;
      if (spurious_err !== 1'b1 || outstanding_ch0 !== 4'd0) begin
         errors++;
         $display("FAIL spurious_sticky got err %b ch0 %0d exp 1 0", spurious_err, outstanding_ch0);
      end
   endtask

   task test_drain_reset();
      int base;
      do_reset();
      for (int i = 0; i < 4; i++) push_req(32'h0000_0A00 + (32'(i) << 4));
      wait_cycles(3);
      checks++;
      if (outstanding_ch0 !== 4'd4) begin
         errors++;
         $display("FAIL drain_pre got ch0 %0d exp 4", outstanding_ch0);
      end
      drain = 1'b1;
      tick();
      base = grants_seen;
      push_req(32'h0000_0B00);
      push_req(32'h8000_0B10);
      wait_cycles(4);
      checks++;
      if (grants_seen - base !== 0 || drain_done !== 1'b0) begin
         errors++;
         $display("FAIL drain_hold got grants %0d done %b exp 0 0", grants_seen - base, drain_done);
      end
      for (int i = 0; i < 4; i++) complete(32'h0000_0A00 + (32'(i) << 4), 1'b1);
      wait_cycles(2);
      checks++;
      if (outstanding_ch0 !== 4'd0 || drain_done !== 1'b0) begin
         errors++;
         $display("FAIL drain_queued got ch0 %0d done %b exp 0 0", outstanding_ch0, drain_done);
      end
      drain = 1'b0;
      wait_cycles(4);
      checks++;
      if (grants_seen - base !== 2 || outstanding_ch0 !== 4'd2) begin
         errors++;
         $display("FAIL drain_resume got grants %0d ch0 %0d exp 2 2", grants_seen - base, outstanding_ch0);
      end
      drain = 1'b1;
      complete(32'h0000_0B00, 1'b1);
      complete(32'h8000_0B10, 1'b1);
      wait_cycles(2);
      checks++;
      if (drain_done !== 1'b1) begin
         errors++;
         $display("FAIL drain_done got %b exp 1", drain_done);
      end
      drain = 1'b0;
      push_req(32'h0000_0C00);
      push_req(32'h0000_0C10);
      reset = 1'b1;
      #1;
      checks++;
      if ({m_grant, write_enable, resp_valid, drain_done, spurious_err} !== 5'b0 ||
          instruction !== 32'h0 || outstanding_ch0 !== 4'd0 ||
          issued_count !== 32'h0 || completed_count !== 32'h0) begin
         errors++;
         $display("FAIL midrun_reset got flags %b instr %h ch0 %0d issued %0d completed %0d exp all 0",
                  {m_grant, write_enable, resp_valid, drain_done, spurious_err},
                  instruction, outstanding_ch0, issued_count, completed_count);
      end
      exp_grant.delete();
      exp_resp.delete();
      tick();
      reset = 1'b0;
      tick();
      complete(32'h0000_0C00, 1'b0);
      checks++;
      if (spurious_err !== 1'b1) begin
         errors++;
         $display("FAIL midrun_forgotten got err %b exp 1", spurious_err);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cycle = 0;
      grants_seen = 0;
      test_reset();
      test_basic();
      test_block();
      test_hol();
      test_simultaneous();
      test_spurious();
      test_drain_reset();
      wait_cycles(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish exp finish before 200000");
      $fatal(1);
   end
endmodule

// File: doc/mem_issuer.md
Name: mem_issuer

Overview:
- Requester-side front end for the banked DRAM memory model.
- Accepts instructions from the core into a small FIFO and presents them one at a time on instruction/m_grant/write_enable.
- Tracks per-channel outstanding slots (10 per channel, channel = address bit 25) so the memory's slot table never overflows.
- Retires completions signalled by the memory's mem_request/data pulse and forwards them to the core.

Parameters:
- FIFO_DEPTH, 8, request FIFO entries; power of 2, at least 2.
- SLOTS_PER_CH, 10, maximum outstanding requests per channel.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core offers req_instr.
- req_instr  in  32  bit 31 = write flag, bits 25:0 = address, bit 25 = channel.
- req_ready  out  1  FIFO not full.
- drain  in  1  level; stop issuing while high.
- instruction  out  32  instruction presented to memory.
- m_grant  out  1  one-cycle issue strobe.
- write_enable  out  1  copy of instruction[31] during grant.
- mem_request  in  1  memory completion pulse.
- data  in  32  completed instruction from memory.
- resp_valid  out  1  one-cycle completion to core.
- resp_data  out  32  completed instruction.
- outstanding_ch0  out  4  in-flight count, channel 0.
- outstanding_ch1  out  4  in-flight count, channel 1.
- issued_count  out  32  total grants issued; wraps.
- completed_count  out  32  total accepted completions; wraps.
- drain_done  out  1  drain high, FIFO and outstanding counts all zero.
- spurious_err  out  1  sticky error flag.

Behaviour:
- Reset (async): FIFO emptied; all counters, outstanding counts, m_grant, write_enable, resp_valid, spurious_err and drain_done = 0; instruction = 0; state = IDLE.
- Enqueue on posedge when req_valid and req_ready.
- req_ready = !full, combinational from registered occupancy.
- A write into an empty FIFO is issuable on the next cycle at the earliest.
- FSM states: IDLE, ISSUE, BLOCKED, DRAIN. Each cycle:
  - DRAIN if drain is high.
  - Else IDLE if the FIFO is empty.
  - Else BLOCKED if the head's channel count = SLOTS_PER_CH.
  - Else ISSUE.
- ISSUE:
  - Pop head; register instruction = head; m_grant = 1 for exactly one cycle; write_enable = head[31].
  - Increment that channel's outstanding count and issued_count.
  - Back-to-back grants allowed, one per cycle.
  - Strict head-of-line order: a blocked head stalls younger requests even on the other channel.
- When not granting: m_grant = 0, write_enable = 0, instruction holds its last value.
- Completion:
  - When mem_request is sampled high, channel = data[25].
  - If that channel's count > 0: decrement it, increment completed_count, resp_valid = 1 next cycle, resp_data = data.
  - If the count = 0: no decrement, no resp_valid, spurious_err set (sticky until reset).
- Simultaneous issue and completion on the same channel: count unchanged, both counters increment. A channel at SLOTS_PER_CH with a completion this cycle is still BLOCKED this cycle; it may issue next cycle.
- drain:
  - Takes effect on the next edge; a grant already registered completes.
  - Enqueue stays enabled during drain.
  - drain_done is registered = drain && FIFO empty && both counts 0.
- Count widths: 4-bit outstanding counts saturate by construction and never exceed SLOTS_PER_CH. 32-bit counters wrap modulo 2^32.
- Reset mid-operation: in-flight requests are forgotten; completions arriving afterwards raise spurious_err.

Optional Feature:
- Macro: MEM_ISSUER_TIMEOUT_EN.
- When defined:
  - Add a 32-bit watchdog counter that increments each cycle while (outstanding_ch0 + outstanding_ch1) > 0 and no valid completion arrives.
  - The counter clears on any valid completion or when the total reaches 0.
  - On reaching TIMEOUT_CYCLES, sticky output timeout_err (1 bit) = 1 until reset.
- When undefined: no watchdog logic and no timeout_err port.

Decomposition:
- Shared package mem_pkg holds:
  - CH_BIT = 25, WR_BIT = 31, ADDR_W = 26, SLOTS_PER_CH default.
  - Channel index typedef (1 bit).
  - FSM state enum {IDLE, ISSUE, BLOCKED, DRAIN}.
- One sub-module: issue_fifo.
  - Synchronous FIFO, parameterised depth and width.
  - Interface: push/pop/full/empty/head; asynchronous active-high reset.
- Credit tracking and the FSM stay in mem_issuer.

Test Plan:
- Push 3 requests on channel 0 (addresses 0x0000400, 0x0000800, 0x0000C00) with no completions -> grants on 3 consecutive cycles, outstanding_ch0 = 3, issued_count = 3.
- Push 12 requests on channel 1 (bit 25 set), no completions -> exactly 10 grants, state BLOCKED, outstanding_ch1 = 10. Then one mem_request with data bit 25 = 1 -> 11th grant on the following cycle.
- Channel 0 full (10 outstanding), head on channel 0, next entry on channel 1 -> no grant for the channel-1 entry (head-of-line) until a channel-0 completion arrives.
- At outstanding_ch0 = 5, a completion on channel 0 and a grant on channel 0 in the same cycle -> outstanding_ch0 stays 5, issued_count and completed_count each +1, resp_data = data.
- mem_request with data bit 25 = 0 while outstanding_ch0 = 0 -> spurious_err = 1, no resp_valid, completed_count unchanged.
- With 4 outstanding and 2 queued, assert drain -> no further grants. After 4 completions, drain_done = 1 only once the FIFO is also empty; with 2 entries still queued it stays 0. Deassert drain -> the 2 queued entries issue. Then pulse reset mid-run -> all outputs return to 0 immediately.
